// File: rtl/scan_sequencer.sv
// Raster-order (row, col) index generator over a ROWS x COLS space, started by a
// start pulse and drained through a valid/ready handshake, with abort.

module scan_wrap_ctr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_max
);
  logic [W-1:0] q_q, q_d;

  // Wrap by compare, so N need not be a power of two.
  assign at_max = (q_q == W'(N - 1));
  assign q      = q_q;

  always_comb begin
    q_d = q_q;
    if (clr)     q_d = '0;
    else if (en) q_d = at_max ? '0 : q_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end
endmodule

module scan_sequencer #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW  = $clog2(ROWS),
  localparam int CW  = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          ready,
  output logic          valid,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last,
  output logic          busy,
  output logic          done
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic       in_run, beat, col_max, row_max, ctr_clr;

  assign in_run  = (state_q == S_RUN);
  assign beat    = in_run & ready;
  // Counters sit at zero outside RUN; abort outranks a coincident accepted beat.
  assign ctr_clr = ~in_run | abort;

  scan_wrap_ctr #(.N(COLS), .W(CW)) u_col (
    .clk(clk), .rst(rst), .clr(ctr_clr), .en(beat),
    .q(col), .at_max(col_max)
  );

  scan_wrap_ctr #(.N(ROWS), .W(RW)) u_row (
    .clk(clk), .rst(rst), .clr(ctr_clr), .en(beat & col_max),
    .q(row), .at_max(row_max)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)                           state_d = S_IDLE;
        else if (beat & row_max & col_max)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign valid = in_run;
  assign busy  = in_run;
  assign last  = in_run & row_max & col_max;
  assign done  = (state_q == S_DONE);
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench: three sequencer instances (3x5, 4x4, 3x3) sharing clock and reset.

module tb_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // DUT A: 3x5
  logic a_start = 0, a_abort = 0, a_ready = 0;
  logic a_valid, a_last, a_busy, a_done;
  logic [1:0] a_row;
  logic [2:0] a_col;
  scan_sequencer #(.ROWS(3), .COLS(5)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .ready(a_ready),
    .valid(a_valid), .row(a_row), .col(a_col), .last(a_last), .busy(a_busy), .done(a_done)
  );

  // DUT B: 4x4
  logic b_start = 0, b_abort = 0, b_ready = 0;
  logic b_valid, b_last, b_busy, b_done;
  logic [1:0] b_row, b_col;
  scan_sequencer #(.ROWS(4), .COLS(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .ready(b_ready),
    .valid(b_valid), .row(b_row), .col(b_col), .last(b_last), .busy(b_busy), .done(b_done)
  );

  // DUT C: 3x3
  logic c_start = 0, c_abort = 0, c_ready = 0;
  logic c_valid, c_last, c_busy, c_done;
  logic [1:0] c_row, c_col;
  scan_sequencer #(.ROWS(3), .COLS(3)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .ready(c_ready),
    .valid(c_valid), .row(c_row), .col(c_col), .last(c_last), .busy(c_busy), .done(c_done)
  );

  typedef struct {
    bit start, abort, ready;
    bit valid, busy, last, done;
    int row, col;
  } vec_t;

  function automatic vec_t mk(bit s, bit a, bit r, bit v, bit b, bit l, bit d, int rw, int cl);
    vec_t t;
    t.start = s; t.abort = a; t.ready = r;
    t.valid = v; t.busy = b; t.last = l; t.done = d; t.row = rw; t.col = cl;
    return t;
  endfunction

  vec_t tab[18];

  initial begin
    int idx, acc;
    bit  got_done;

    // Full 3x5 scan; a start injected mid-run must not disturb the sequence.
    tab[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      tab[1 + i] = mk(i == 6, 0, 1, 1, 1, i == 14, 0, i / 5, i % 5);
    tab[16] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0);
    tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    #1;
    chk("rst_a_valid", a_valid, 0); chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);   chk("rst_a_last", a_last, 0);
    chk("rst_a_row", a_row, 0);     chk("rst_a_col", a_col, 0);
    chk("rst_b_valid", b_valid, 0); chk("rst_c_valid", c_valid, 0);
    @(negedge clk); rst = 0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      a_start = tab[i].start; a_abort = tab[i].abort; a_ready = tab[i].ready;
      #1;
      chk($sformatf("tab%0d_valid", i), a_valid, tab[i].valid);
      chk($sformatf("tab%0d_busy", i), a_busy, tab[i].busy);
      chk($sformatf("tab%0d_last", i), a_last, tab[i].last);
      chk($sformatf("tab%0d_done", i), a_done, tab[i].done);
      chk($sformatf("tab%0d_row", i), a_row, tab[i].row);
      chk($sformatf("tab%0d_col", i), a_col, tab[i].col);
    end
    a_start = 0; a_ready = 0;

    // Backpressure on 4x4 with random ready.
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0;
    idx = 0; acc = 0; got_done = 0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      b_ready = 1'($urandom_range(0, 1));
      #1;
      if (idx < 16) begin
        chk("bp_valid", b_valid, 1);
        chk("bp_row", b_row, idx / 4);
        chk("bp_col", b_col, idx % 4);
        chk("bp_last", b_last, idx == 15);
        chk("bp_done", b_done, 0);
        if (b_ready) begin acc++; idx++; end
      end else begin
        chk("bp_done_after_last", b_done, 1);
        chk("bp_valid_at_done", b_valid, 0);
        got_done = 1;
      end
    end
    chk("bp_done_seen", got_done, 1);
    chk("bp_accepts", acc, 16);
    b_ready = 0;
    @(negedge clk); #1;
    chk("bp_idle_done", b_done, 0); chk("bp_idle_busy", b_busy, 0);

    // 3x3 non-power-of-2 wrap.
    @(negedge clk); c_start = 1; c_ready = 1;
    @(negedge clk); c_start = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("np2_valid", c_valid, 1);
      chk("np2_col", c_col, i % 3);
      chk("np2_row", c_row, i / 3);
      chk("np2_last", c_last, i == 8);
    end
    @(negedge clk); #1;
    chk("np2_done", c_done, 1); chk("np2_row_wrap", c_row, 0); chk("np2_col_wrap", c_col, 0);
    @(negedge clk); #1;
    chk("np2_done_once", c_done, 0); chk("np2_busy_idle", c_busy, 0);

    // start+abort together in IDLE: start wins; then abort on the last beat.
    c_start = 1; c_abort = 1;
    @(negedge clk); c_start = 0; c_abort = 0; #1;
    chk("sa_valid", c_valid, 1); chk("sa_row", c_row, 0); chk("sa_col", c_col, 0);
    repeat (8) @(negedge clk);
    #1;
    chk("al_last", c_last, 1); chk("al_row", c_row, 2); chk("al_col", c_col, 2);
    c_abort = 1;
    @(negedge clk); c_abort = 0; #1;
    chk("al_no_done", c_done, 0); chk("al_valid", c_valid, 0); chk("al_busy", c_busy, 0);
    @(negedge clk); #1;
    chk("al_no_done2", c_done, 0);
    c_ready = 0;

    // Abort mid-scan on 3x5 at (1,2), then restart.
    @(negedge clk); a_start = 1; a_ready = 1;
    @(negedge clk); a_start = 0;
    repeat (7) @(negedge clk);
    #1;
    chk("ab_row", a_row, 1); chk("ab_col", a_col, 2);
    a_abort = 1;
    @(negedge clk); a_abort = 0; #1;
    chk("ab_valid", a_valid, 0); chk("ab_busy", a_busy, 0);
    chk("ab_row0", a_row, 0); chk("ab_col0", a_col, 0); chk("ab_done", a_done, 0);
    @(negedge clk); #1;
    chk("ab_no_done", a_done, 0);
    a_start = 1;
    @(negedge clk); #1;
    chk("rs_valid", a_valid, 1); chk("rs_row", a_row, 0); chk("rs_col", a_col, 0);

    // start during RUN ignored, then async reset at (2,1) between edges.
    @(negedge clk); a_start = 0; #1;
    chk("ign_row", a_row, 0); chk("ign_col", a_col, 1);
    repeat (10) @(negedge clk);
    #1;
    chk("pre_rst_row", a_row, 2); chk("pre_rst_col", a_col, 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", a_valid, 0); chk("arst_busy", a_busy, 0);
    chk("arst_row", a_row, 0);     chk("arst_col", a_col, 0);
    @(negedge clk); rst = 0; a_ready = 0;
    @(negedge clk); #1;
    chk("post_rst_idle", a_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
